// File: rtl/uart_link_ctrl.sv
// UART link endpoint: RX deserializer, SYNC/ACK handshake with timeout/retry, RX FIFO, TX serializer.
// Optional build macro UART_ECHO_EN retransmits every byte received while LINKED.
module uart_link_ctrl #(
    parameter int                CLKS_PER_BIT   = 5208,
    parameter int                DATA_W         = 8,
    parameter int                FIFO_DEPTH     = 8,
    parameter int                TIMEOUT_CYCLES = 500_000_000,
    parameter logic [DATA_W-1:0] SYNC_BYTE      = DATA_W'(8'h55),
    parameter logic [DATA_W-1:0] ACK_BYTE       = DATA_W'(8'hAA)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          retry,
    input  logic                          i_Rx_Serial,
    output logic                          o_Tx_Serial,
    output logic                          link_up,
    output logic                          link_fail,
    output logic [3:0]                    status_code,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DATA_W-1:0]             last_byte,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_WAIT_SYNC, ST_SEND_ACK, ST_LINKED, ST_FAIL} link_state_t;

    rx_state_t           rx_state;
    logic                rx_sync_p0, rx_sync_p1, rx_sync_p2;
    logic [CNT_W-1:0]    rx_cnt;
    logic [BIT_W-1:0]    rx_bit;
    logic [DATA_W-1:0]   rx_byte_p0;
    logic                rx_vld_p0, rx_ferr_p0;

    link_state_t         link_state;
    logic [TMR_W-1:0]    timer;
    logic                tx_go;
    logic [DATA_W-1:0]   tx_byte_p0;

    logic                tx_busy, tx_line;
    logic [CNT_W-1:0]    tx_cnt;
    logic [BIT_W-1:0]    tx_bit;
    logic [DATA_W:0]     tx_shift;
    logic                tx_last;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                restart, push_req, pop, full, do_push;

    // RX stage: 2-FF synchronizer, edge detect, mid-bit sampling
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_sync_p2 <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_vld_p0  <= 1'b0;
            rx_ferr_p0 <= 1'b0;
        end else begin
            rx_sync_p0 <= i_Rx_Serial;
            rx_sync_p1 <= rx_sync_p0;
            rx_sync_p2 <= rx_sync_p1;
            rx_vld_p0  <= 1'b0;
            rx_ferr_p0 <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync_p1 && rx_sync_p2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == BIT_W'(DATA_W - 1))
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt     <= '0;
                        rx_vld_p0  <= rx_sync_p1;
                        rx_ferr_p0 <= !rx_sync_p1;
                        rx_state   <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rx_state == RX_DATA && rx_cnt == CNT_W'(CLKS_PER_BIT - 1))
            rx_byte_p0 <= {rx_sync_p1, rx_byte_p0[DATA_W-1:1]};
    end

    // Handshake FSM: status outputs registered alongside the state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link_state  <= ST_WAIT_SYNC;
            timer       <= '0;
            link_up     <= 1'b0;
            link_fail   <= 1'b0;
            status_code <= 4'h0;
            tx_go       <= 1'b0;
        end else begin
            tx_go <= 1'b0;
            case (link_state)
                ST_WAIT_SYNC: begin
                    if (rx_vld_p0 && rx_byte_p0 == SYNC_BYTE) begin
                        link_state <= ST_SEND_ACK;
                        tx_go      <= 1'b1;
                        timer      <= '0;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        link_state  <= ST_FAIL;
                        link_fail   <= 1'b1;
                        status_code <= 4'hF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SEND_ACK: begin
                    if (tx_last) begin
                        link_state  <= ST_LINKED;
                        link_up     <= 1'b1;
                        status_code <= 4'hE;
                    end
                end
                ST_LINKED: begin
`ifdef UART_ECHO_EN
                    if (rx_vld_p0 && !tx_busy && !tx_go)
                        tx_go <= 1'b1;
`endif
                end
                ST_FAIL: begin
                    if (retry) begin
                        link_state  <= ST_WAIT_SYNC;
                        link_fail   <= 1'b0;
                        status_code <= 4'h0;
                        timer       <= '0;
                    end
                end
                default: link_state <= ST_WAIT_SYNC;
            endcase
        end
    end

`ifdef UART_ECHO_EN
    // Strobes are a full frame apart, so the byte is stable when the serializer loads it.
    always_ff @(posedge clock) begin
        if (link_state != ST_LINKED)
            tx_byte_p0 <= ACK_BYTE;
        else if (rx_vld_p0)
            tx_byte_p0 <= rx_byte_p0;
    end
`else
    assign tx_byte_p0 = ACK_BYTE;
`endif

    // TX stage: start bit, DATA_W data bits LSB first, stop bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (tx_go) begin
            tx_busy <= 1'b1;
            tx_line <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                tx_cnt <= '0;
                tx_bit <= tx_bit + 1'b1;
                if (tx_bit == BIT_W'(DATA_W + 1)) begin
                    tx_busy <= 1'b0;
                    tx_line <= 1'b1;
                end else begin
                    tx_line <= tx_shift[0];
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (tx_go)
            tx_shift <= {1'b1, tx_byte_p0};
        else if (tx_busy && tx_cnt == CNT_W'(CLKS_PER_BIT - 1))
            tx_shift <= {1'b1, tx_shift[DATA_W:1]};
    end

    assign tx_last     = tx_busy && (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) &&
                         (tx_bit == BIT_W'(DATA_W + 1));
    assign o_Tx_Serial = tx_line;

    // FIFO stage: show-ahead head, drop-on-full with sticky overflow
    assign restart  = (link_state == ST_FAIL) && retry;
    assign push_req = (link_state == ST_LINKED) && rx_vld_p0;
    assign rx_valid = (fifo_level != '0);
    assign pop      = rx_valid && rx_ready;
    assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign do_push  = push_req && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            last_byte  <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (restart) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                overflow   <= 1'b0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({do_push, pop})
                    2'b10:   fifo_level <= fifo_level + 1'b1;
                    2'b01:   fifo_level <= fifo_level - 1'b1;
                    default: fifo_level <= fifo_level;
                endcase
                if (push_req && full && !pop)
                    overflow <= 1'b1;
            end
            if (push_req)
                last_byte <= rx_byte_p0;
            if (link_state == ST_LINKED && rx_ferr_p0)
                frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= rx_byte_p0;
    end

endmodule
